timer_dev: RTL and testbench
============================

# timer_dev

Memory-mapped countdown timer on the CPU data bus. It answers `m_data_addr`/`m_data_wdata`/`m_data_byteen` accesses routed by the system bridge and returns read data. Its interrupt output drives one bit of the CPU's `HWInt[15:10]` (bit 10 in the default system). It is the device-side responder to the CPU's memory stage, and it is the source that the CPU's CP0 samples for interrupt requests.

## Interface
Parameters:
- `BASE_OFFSET_BITS`, default 2: word-offset field width. It selects 3 registers, and offset 3 is reserved.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-low. Clears all state immediately.
- `sel` in 1: bridge chip-select; this device is addressed this cycle.
- `addr` in 2: word offset (`m_data_addr[3:2]`).
- `byteen` in 4: byte-lane write enables. Any nonzero value with `sel` means a write.
- `wdata` in 32: write data, already lane-aligned by the CPU byte-enable logic.
- `rdata` out 32: combinational read data for `addr`.
- `irq` out 1: interrupt request to `HWInt`, registered.

## Operation
Registers:
- Offset 0, CTRL, R/W:
  - bit 0 EN: count enable.
  - bits [2:1] MODE: 00 = one-shot, 01 = auto-reload, 10/11 behave as 00.
  - bit 3 IM: interrupt mask, 1 = enabled.
  - bits [31:4] read 0, writes ignored.
- Offset 1, PRESET, R/W: full 32 bits.
- Offset 2, COUNT, read-only. Writes are ignored.
- Offset 3: reads 0, writes ignored.

Writes:
- Per byte lane: lane i updates bits [8i+7:8i] when `byteen[i]=1`.
- Every write to CTRL, regardless of lanes, clears `int_flag`.

Reads:
- `rdata` is a pure function of `addr` and the current register values. It does not depend on `sel`, and a read has no side effects.

FSM states: IDLE, LOAD, CNT, INT. Reset state is IDLE.
- **IDLE**: if EN=1, go to LOAD.
- **LOAD**: COUNT ← PRESET, go to CNT.
- **CNT**:
  - If EN=0, go to IDLE and hold COUNT.
  - Else if COUNT > 1: COUNT ← COUNT−1.
  - Else (COUNT is 1 or 0): COUNT ← 0 and go to INT.
- **INT**: set `int_flag`.
  - MODE one-shot: clear EN, go to IDLE. `int_flag` holds until the next CTRL write.
  - MODE auto-reload: go to IDLE (EN still 1, so it reloads). `int_flag` is cleared on the following edge, giving a 1-cycle pulse.

Output:
- `irq` = IM & `int_flag`, registered.

Simultaneous events:
- A CPU write to CTRL in the same cycle the FSM clears EN (INT state, one-shot): the CPU write wins for EN.
- A write to PRESET during CNT does not affect the running COUNT. It takes effect at the next LOAD.
- An EN=0 write takes effect at the edge that commits it. The FSM sees EN=0 on the next evaluation.

Reset values: CTRL=0, PRESET=0, COUNT=0, state IDLE, `int_flag`=0, `irq`=0. `rdata` reflects these zeros. Reset mid-count aborts immediately, with no `irq` glitch.

## Timing
- Write commit: edge E0, where `sel` and `byteen` are sampled.
- With EN written 1 at E0 and PRESET=N≥1:
  - E1: state LOAD.
  - E2: COUNT=N.
  - E(2+k): COUNT=N−k.
  - E(N+2): COUNT=0, state INT.
  - E(N+3): `int_flag`=1 and `irq`=1 when IM=1.
- PRESET=0 behaves exactly like PRESET=1.
- Auto-reload period: N+3 cycles between `irq` rising edges (INT → IDLE → LOAD → CNT…).
- Read latency is 0 cycles. The CPU samples `rdata` in the same M-stage cycle.
- COUNT never wraps: the decrement is guarded at 1. Arithmetic is 32-bit unsigned.

## Test plan
- **Reset:** drive `reset`=0 asynchronously mid-cycle during CNT with COUNT=0x10 → all registers read 0 immediately, and `irq`=0 with no pulse.
- **One-shot:**
  - Stimulus: write PRESET=5, then CTRL=0x9 (EN, IM, one-shot) at E0.
  - Required: COUNT reads 5 after E2 and 1 after E6. `irq` rises after E8 and stays high. CTRL reads 0x8 (EN cleared). Writing CTRL=0x8 drops `irq` the next cycle.
- **Auto-reload:**
  - Stimulus: PRESET=3, CTRL=0xB.
  - Required: `irq` is a 1-cycle pulse every 6 cycles, for at least 3 periods.
- **Masked:** CTRL=0x1, PRESET=2 → `int_flag` sets but `irq` stays 0. A later write of CTRL=0x8 does not raise `irq`, because the CTRL write clears the flag.
- **Byte lanes and reserved:**
  - Write PRESET with `byteen`=0b0010 and wdata=0xAABBCCDD over 0x11223344 → PRESET=0x1122CC44.
  - A write to COUNT or offset 3 changes nothing. Offset 3 reads 0.
- **Mid-count updates:**
  - During CNT, write PRESET=100 → current countdown finishes on the old value.
  - Write CTRL EN=0 at COUNT=7 → COUNT freezes at 6 or 7 per edge order, and the state returns to IDLE.
  - Re-enabling reloads from 100.

Source files
------------

// File: rtl/timer_dev.sv
// timer_dev: memory-mapped 32-bit countdown timer with interrupt output.
//
// Register map (word offsets):
//   0 CTRL   R/W  bit0 EN, bits[2:1] MODE (01 = auto-reload, else one-shot),
//                 bit3 IM (interrupt mask, 1 = enabled); upper bits read 0
//   1 PRESET R/W  reload value loaded into COUNT on each LOAD
//   2 COUNT  RO   current down-counter value
//   3 ---         reads 0, writes ignored
//
// Ports:
//   clk     - clock, all state updates on the rising edge
//   reset   - asynchronous active-low reset
//   sel     - chip select from the bus bridge
//   addr    - word offset of the access
//   byteen  - byte-lane write enables; nonzero with sel means a write
//   wdata   - lane-aligned write data
//   rdata   - combinational read data for addr
//   irq     - registered interrupt request (IM & int_flag)

module timer_dev #(
    parameter int BASE_OFFSET_BITS = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        sel,
    input  logic [BASE_OFFSET_BITS-1:0] addr,
    input  logic [3:0]                  byteen,
    input  logic [31:0]                 wdata,
    output logic [31:0]                 rdata,
    output logic                        irq
);

    localparam logic [BASE_OFFSET_BITS-1:0] OFF_CTRL   = BASE_OFFSET_BITS'(0);
    localparam logic [BASE_OFFSET_BITS-1:0] OFF_PRESET = BASE_OFFSET_BITS'(1);
    localparam logic [BASE_OFFSET_BITS-1:0] OFF_COUNT  = BASE_OFFSET_BITS'(2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    state_t      state_reg,   state_next;
    logic [3:0]  ctrl_reg,    ctrl_next;
    logic [31:0] preset_reg,  preset_next;
    logic [31:0] count_reg,   count_next;
    logic        int_flag_reg, int_flag_next;
    logic        irq_reg,     irq_next;

    logic        wr_any;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        ctrl_en;
    logic        ctrl_auto;
    logic        fsm_clear_en;
    logic        fsm_int_set;

    assign wr_any    = sel & (|byteen);
    assign wr_ctrl   = wr_any & (addr == OFF_CTRL);
    assign wr_preset = wr_any & (addr == OFF_PRESET);

    assign ctrl_en   = ctrl_reg[0];
    // MODE 10/11 fall back to one-shot behaviour.
    assign ctrl_auto = (ctrl_reg[2:1] == 2'b01);

    // PRESET byte-lane merge.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_preset_lane
            assign preset_next[8*gi +: 8] = (wr_preset && byteen[gi])
                                          ? wdata[8*gi +: 8]
                                          : preset_reg[8*gi +: 8];
        end
    endgenerate

    // Countdown FSM.
    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        fsm_clear_en = 1'b0;
        fsm_int_set  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (ctrl_en) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_next = preset_reg;
                state_next = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_en) begin
                    state_next = ST_IDLE;
                end else if (count_reg > 32'd1) begin
                    count_next = count_reg - 32'd1;
                end else begin
                    // Guarded at 1 so a PRESET of 0 never wraps.
                    count_next = 32'd0;
                    state_next = ST_INT;
                end
            end
            ST_INT: begin
                fsm_int_set = 1'b1;
                state_next  = ST_IDLE;
                if (!ctrl_auto) begin
                    fsm_clear_en = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // CTRL: the FSM's one-shot EN clear is applied first so a CPU write to
    // lane 0 in the same cycle overrides it.
    always_comb begin
        ctrl_next = ctrl_reg;
        if (fsm_clear_en) begin
            ctrl_next[0] = 1'b0;
        end
        if (wr_ctrl && byteen[0]) begin
            ctrl_next = wdata[3:0];
        end
    end

    // int_flag: set leaving INT; any CTRL write clears it; in auto-reload it
    // lives for a single cycle.
    always_comb begin
        int_flag_next = int_flag_reg;
        if (fsm_int_set) begin
            int_flag_next = 1'b1;
        end else if (wr_ctrl || ctrl_auto) begin
            int_flag_next = 1'b0;
        end
    end

    // irq is registered from the next-state values so it rises on the same
    // edge as int_flag and drops on the edge that commits a CTRL write.
    assign irq_next = ctrl_next[3] & int_flag_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            ctrl_reg     <= 4'd0;
            preset_reg   <= 32'd0;
            count_reg    <= 32'd0;
            int_flag_reg <= 1'b0;
            irq_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ctrl_reg     <= ctrl_next;
            preset_reg   <= preset_next;
            count_reg    <= count_next;
            int_flag_reg <= int_flag_next;
            irq_reg      <= irq_next;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (addr)
            OFF_CTRL:   rdata = {28'd0, ctrl_reg};
            OFF_PRESET: rdata = preset_reg;
            OFF_COUNT:  rdata = count_reg;
            default:    rdata = 32'd0;
        endcase
    end

    assign irq = irq_reg;

endmodule

// File: tb/tb_timer_dev.sv
// Directed testbench for timer_dev: table-driven register access vectors plus
// hand-written multi-cycle sequences for counting, interrupts and reset.

module tb_timer_dev;

    logic        clk;
    logic        reset;
    logic        sel;
    logic [1:0]  addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int errors = 0;
    int checks = 0;

    timer_dev dut (
        .clk    (clk),
        .reset  (reset),
        .sel    (sel),
        .addr   (addr),
        .byteen (byteen),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic        s;
        logic [1:0]  a;
        logic [3:0]  be;
        logic [31:0] d;
        logic [1:0]  ra;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one bus write committed at the next rising edge; returns 1 time
    // unit after that edge.
    task automatic wr(input logic s, input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
        @(negedge clk);
        sel    = s;
        addr   = a;
        byteen = be;
        wdata  = d;
        @(posedge clk);
        #1;
        sel    = 1'b0;
        byteen = 4'd0;
        wdata  = 32'd0;
        $display("write sel=%0b addr=%0d byteen=%04b data=0x%08h", s, a, be, d);
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(name, rdata, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset  = 1'b0;
        sel    = 1'b0;
        addr   = 2'd0;
        byteen = 4'd0;
        wdata  = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;

        // Reset state
        rd_chk("rst_ctrl",   2'd0, 32'd0);
        rd_chk("rst_preset", 2'd1, 32'd0);
        rd_chk("rst_count",  2'd2, 32'd0);
        rd_chk("rst_off3",   2'd3, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);

        // Register access vectors (EN kept 0 so nothing counts)
        vecs[0] = '{1'b1, 2'd1, 4'hF, 32'h11223344, 2'd1, 32'h11223344};
        vecs[1] = '{1'b1, 2'd1, 4'h2, 32'hAABBCCDD, 2'd1, 32'h1122CC44};
        vecs[2] = '{1'b1, 2'd1, 4'h8, 32'hAABBCCDD, 2'd1, 32'hAA22CC44};
        vecs[3] = '{1'b1, 2'd2, 4'hF, 32'hFFFFFFFF, 2'd2, 32'h00000000};
        vecs[4] = '{1'b1, 2'd3, 4'hF, 32'hFFFFFFFF, 2'd3, 32'h00000000};
        vecs[5] = '{1'b1, 2'd3, 4'hF, 32'h00000000, 2'd1, 32'hAA22CC44};
        vecs[6] = '{1'b1, 2'd0, 4'hF, 32'hFFFFFFF6, 2'd0, 32'h00000006};
        vecs[7] = '{1'b1, 2'd0, 4'hE, 32'hFFFFFFFF, 2'd0, 32'h00000006};
        vecs[8] = '{1'b0, 2'd1, 4'hF, 32'h00000000, 2'd1, 32'hAA22CC44};
        vecs[9] = '{1'b1, 2'd0, 4'h1, 32'h00000000, 2'd0, 32'h00000000};
        for (int i = 0; i < 10; i++) begin
            wr(vecs[i].s, vecs[i].a, vecs[i].be, vecs[i].d);
            rd_chk($sformatf("vec%0d", i), vecs[i].ra, vecs[i].exp);
        end

        // One-shot, PRESET=5, CTRL=0x9
        wr(1'b1, 2'd1, 4'hF, 32'd5);
        wr(1'b1, 2'd0, 4'hF, 32'h9);        // E0
        tick(2);
        rd_chk("os_count_e2", 2'd2, 32'd5);
        tick(4);
        rd_chk("os_count_e6", 2'd2, 32'd1);
        check("os_irq_e6", {31'd0, irq}, 32'd0);
        tick(1);
        check("os_irq_e7", {31'd0, irq}, 32'd0);
        tick(1);
        check("os_irq_e8", {31'd0, irq}, 32'd1);
        rd_chk("os_ctrl_en_clr", 2'd0, 32'h8);
        tick(3);
        check("os_irq_hold", {31'd0, irq}, 32'd1);
        rd_chk("os_count_zero", 2'd2, 32'd0);
        wr(1'b1, 2'd0, 4'hF, 32'h8);
        check("os_irq_clr", {31'd0, irq}, 32'd0);

        // PRESET=0 times exactly like PRESET=1
        wr(1'b1, 2'd1, 4'hF, 32'd0);
        wr(1'b1, 2'd0, 4'hF, 32'h9);
        tick(3);
        check("p0_irq_e3", {31'd0, irq}, 32'd0);
        tick(1);
        check("p0_irq_e4", {31'd0, irq}, 32'd1);
        wr(1'b1, 2'd0, 4'hF, 32'h0);
        check("p0_irq_clr", {31'd0, irq}, 32'd0);

        // Auto-reload, PRESET=3, CTRL=0xB: pulse after E6, E12, E18
        wr(1'b1, 2'd1, 4'hF, 32'd3);
        wr(1'b1, 2'd0, 4'hF, 32'hB);
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            check($sformatf("auto_irq_e%0d", k), {31'd0, irq}, (k % 6 == 0) ? 32'd1 : 32'd0);
        end
        wr(1'b1, 2'd0, 4'hF, 32'h0);
        tick(3);

        // Masked: CTRL=0x1, PRESET=2; INT at E4, flag at E5
        wr(1'b1, 2'd1, 4'hF, 32'd2);
        wr(1'b1, 2'd0, 4'hF, 32'h1);
        tick(5);
        check("mask_flag_set", {31'd0, dut.int_flag_reg}, 32'd1);
        check("mask_irq", {31'd0, irq}, 32'd0);
        rd_chk("mask_ctrl", 2'd0, 32'h0);
        wr(1'b1, 2'd0, 4'hF, 32'h8);
        check("mask_flag_clr", {31'd0, dut.int_flag_reg}, 32'd0);
        tick(2);
        check("mask_irq_after_im", {31'd0, irq}, 32'd0);
        wr(1'b1, 2'd0, 4'hF, 32'h0);

        // Mid-count PRESET write and EN=0 freeze
        wr(1'b1, 2'd1, 4'hF, 32'd20);
        wr(1'b1, 2'd0, 4'hF, 32'h1);
        tick(3);
        rd_chk("mid_count_e3", 2'd2, 32'd19);
        wr(1'b1, 2'd1, 4'hF, 32'd100);      // E4
        rd_chk("mid_count_old", 2'd2, 32'd18);
        rd_chk("mid_preset_new", 2'd1, 32'd100);
        tick(10);
        rd_chk("mid_count_e14", 2'd2, 32'd8);
        wr(1'b1, 2'd0, 4'hF, 32'h0);        // E15: FSM still sees EN=1
        rd_chk("mid_count_e15", 2'd2, 32'd7);
        tick(2);
        rd_chk("mid_count_frozen", 2'd2, 32'd7);
        wr(1'b1, 2'd0, 4'hF, 32'h1);
        tick(2);
        rd_chk("mid_reload", 2'd2, 32'd100);
        tick(1);
        rd_chk("mid_reload_dec", 2'd2, 32'd99);
        wr(1'b1, 2'd0, 4'hF, 32'h0);
        tick(2);

        // Asynchronous reset mid-count at COUNT=0x10
        wr(1'b1, 2'd1, 4'hF, 32'h20);
        wr(1'b1, 2'd0, 4'hF, 32'h9);
        tick(18);
        rd_chk("rst_pre_count", 2'd2, 32'h10);
        #3;
        reset = 1'b0;
        #1;
        rd_chk("arst_ctrl",   2'd0, 32'd0);
        rd_chk("arst_preset", 2'd1, 32'd0);
        rd_chk("arst_count",  2'd2, 32'd0);
        check("arst_irq", {31'd0, irq}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check($sformatf("arst_irq_hold%0d", k), {31'd0, irq}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        tick(3);
        rd_chk("post_rst_count", 2'd2, 32'd0);
        check("post_rst_irq", {31'd0, irq}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
